// File: rtl/cost_luma_pkg.sv
// Shared types and constants for the luma mode-decision scheduler and its RD cost datapath.
// No logic here; latency and backpressure are defined by the modules that use it.
package cost_luma_pkg;

  localparam int MAX_MODES   = 8;
  localparam int TIMEOUT_CYC = 63;
  localparam int SUM_W       = 32;
  localparam int LAMBDA_W    = 16;
  localparam int RATE_W      = 16;
  localparam int CALC_W      = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RUN,
    ST_WAIT,
    ST_CMP,
    ST_FIN
  } state_t;

  function automatic logic [3:0] clamp_modes(input logic [3:0] n);
    return (n > 4'(MAX_MODES)) ? 4'(MAX_MODES) : n;
  endfunction

endpackage

// File: rtl/cost_luma_rd_calc.sv
// RD score = sum + lambda*rate at 48 bits, saturated to 32 bits; purely combinational.
// No handshake; the caller samples the score when its strobe is valid.
module cost_luma_rd_calc
  import cost_luma_pkg::*;
(
  input  logic [SUM_W-1:0]    sum,
  input  logic [LAMBDA_W-1:0] lambda,
  input  logic [RATE_W-1:0]   rate,
  output logic [SUM_W-1:0]    score
);

  logic [CALC_W-1:0] full;

  always_comb begin
    full  = CALC_W'(sum) + CALC_W'(lambda) * CALC_W'(rate);
    score = (|full[CALC_W-1:SUM_W]) ? '1 : full[SUM_W-1:0];
  end

endmodule

// File: rtl/cost_luma_sched.sv
// Sequences one macroblock mode search across the cost engine and keeps the lowest RD score; 21 cycles per mode at 18-cycle engine latency.
// Stalls in REQ until mode_ack and in WAIT until eng_done or a 63-cycle timeout; abort returns to IDLE from any state.
module cost_luma_sched
  import cost_luma_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0]          num_modes,
  input  logic [LAMBDA_W-1:0] lambda,
  input  logic                abort,
  output logic                mode_req,
  output logic [2:0]          mode_idx,
  input  logic                mode_ack,
  input  logic [RATE_W-1:0]   mode_rate,
  output logic                eng_start,
  input  logic                eng_done,
  input  logic [SUM_W-1:0]    eng_sum,
  output logic [2:0]          best_mode,
  output logic [SUM_W-1:0]    best_score,
  output logic                done,
  output logic                err,
  output logic                busy
);

  state_t              state, state_nxt;
  logic [3:0]          num_q;
  logic [LAMBDA_W-1:0] lambda_q;
  logic [RATE_W-1:0]   rate_q;
  logic [SUM_W-1:0]    score_q;
  logic [SUM_W-1:0]    score_calc;
  logic [5:0]          to_cnt;
  logic                last_mode;
  logic                timeout;

  cost_luma_rd_calc u_rd_calc (
    .sum    (eng_sum),
    .lambda (lambda_q),
    .rate   (rate_q),
    .score  (score_calc)
  );

  assign last_mode = ({1'b0, mode_idx} == (num_q - 4'd1));
  // Fires on the WAIT cycle whose increment brings the counter to 63.
  assign timeout   = (to_cnt == 6'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_nxt = (clamp_modes(num_modes) == 4'd0) ? ST_FIN : ST_REQ;
        ST_REQ:  if (mode_ack) state_nxt = ST_RUN;
        ST_RUN:  state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (eng_done)     state_nxt = ST_CMP;
          else if (timeout) state_nxt = ST_FIN;
        end
        ST_CMP:  state_nxt = last_mode ? ST_FIN : ST_REQ;
        ST_FIN:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_q      <= '0;
      lambda_q   <= '0;
      rate_q     <= '0;
      score_q    <= '0;
      to_cnt     <= '0;
      mode_idx   <= '0;
      best_mode  <= '0;
      best_score <= '0;
      err        <= 1'b0;
    end else if (!abort) begin
      case (state)
        ST_IDLE: if (start) begin
          num_q      <= clamp_modes(num_modes);
          lambda_q   <= lambda;
          mode_idx   <= '0;
          best_mode  <= '0;
          best_score <= '1;
          err        <= 1'b0;
        end
        ST_REQ:  if (mode_ack) rate_q <= mode_rate;
        ST_RUN:  to_cnt <= '0;
        ST_WAIT: begin
          to_cnt <= to_cnt + 6'd1;
          if (eng_done)     score_q <= score_calc;
          else if (timeout) err <= 1'b1;
        end
        ST_CMP: begin
          // Strict compare so an equal later score never displaces a lower index.
          if (score_q < best_score) begin
            best_score <= score_q;
            best_mode  <= mode_idx;
          end
          if (!last_mode) mode_idx <= mode_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign mode_req  = (state == ST_REQ);
  assign eng_start = (state == ST_RUN);
  assign done      = (state == ST_FIN);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_cost_luma_sched.sv
// Directed bench for cost_luma_sched: a scripted engine answers each mode and results are compared against hand-worked values.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_cost_luma_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  num_modes;
  logic [15:0] lambda;
  logic        abort;
  logic        mode_req;
  logic [2:0]  mode_idx;
  logic        mode_ack;
  logic [15:0] mode_rate;
  logic        eng_start;
  logic        eng_done;
  logic [31:0] eng_sum;
  logic [2:0]  best_mode;
  logic [31:0] best_score;
  logic        done;
  logic        err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] rates[8];
  logic [31:0] sums[8];
  int g_starts, g_dones, g_mask, g_done_cyc, g_es_cyc;
  logic g_busy_after_abort;

  always #5 clk = ~clk;

  cost_luma_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_modes  (num_modes),
    .lambda     (lambda),
    .abort      (abort),
    .mode_req   (mode_req),
    .mode_idx   (mode_idx),
    .mode_ack   (mode_ack),
    .mode_rate  (mode_rate),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .eng_sum    (eng_sum),
    .best_mode  (best_mode),
    .best_score (best_score),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a search and play the engine: immediate ack, eng_done 'lat' cycles after
  // eng_start (0 = never). abort_mode >= 0 aborts in WAIT of that mode, then
  // replays a stale eng_done 5 cycles later.
  task automatic run_search(input logic [3:0] nm, input logic [15:0] lam,
                            input int lat, input int abort_mode);
    int  cnt, cur, post;
    bit  ab_next, aborted;
    g_starts = 0; g_dones = 0; g_mask = 0; g_done_cyc = -1; g_es_cyc = -1;
    g_busy_after_abort = 1'b1;
    cnt = 0; cur = 0; post = 0; ab_next = 0; aborted = 0;
    num_modes = nm; lambda = lam; start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      eng_done = 1'b0;
      abort    = 1'b0;
      if (aborted) begin
        post++;
        if (post == 1) g_busy_after_abort = busy;
        if (post > 12) break;
      end
      if (done) begin
        g_dones++;
        g_done_cyc = cyc;
      end
      if (g_dones > 0 && cyc >= g_done_cyc + 3) break;
      mode_ack  = mode_req;
      mode_rate = rates[mode_idx];
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_done = 1'b1;
          eng_sum  = sums[cur];
        end
      end
      if (ab_next) begin
        abort   = 1'b1;
        ab_next = 0;
        aborted = 1;
        cnt     = 5;
      end
      if (eng_start) begin
        g_starts++;
        g_mask   |= (1 << mode_idx);
        g_es_cyc  = cyc;
        cur       = int'(mode_idx);
        cnt       = lat;
        if (int'(mode_idx) == abort_mode) ab_next = 1;
      end
      step();
    end
    mode_ack = 1'b0; eng_done = 1'b0; abort = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_modes = '0; lambda = '0; abort = 1'b0;
    mode_ack = 1'b0; mode_rate = '0; eng_done = 1'b0; eng_sum = '0;
    rates = '{default: '0};
    sums  = '{default: '0};
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_best_score", best_score, 0);
    chk("rst_best_mode", best_mode, 0);
    chk("rst_err", err, 0);
    chk("rst_mode_idx", mode_idx, 0);
    rst_n = 1'b1;
    step();

    // Scores 120, 98, 122: mode 1 wins; 3 modes x 21 cycles puts FIN at cycle 64.
    rates = '{16'd10, 16'd4, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    sums  = '{32'd100, 32'd90, 32'd120, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    run_search(4'd3, 16'd2, 18, -1);
    chk("s1_best_mode", best_mode, 1);
    chk("s1_best_score", best_score, 98);
    chk("s1_done_count", g_dones, 1);
    chk("s1_done_cycle", g_done_cyc, 64);
    chk("s1_err", err, 0);
    chk("s1_busy_idle", busy, 0);

    // Abort in WAIT of mode 1; mode 0 scored 7 + 1*3 = 10 and must be retained.
    rates = '{16'd3, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
    sums  = '{32'd7, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
    run_search(4'd4, 16'd1, 18, 1);
    chk("s5_busy_after_abort", g_busy_after_abort, 0);
    chk("s5_no_done", g_dones, 0);
    chk("s5_starts", g_starts, 2);
    chk("s5_best_score_held", best_score, 10);
    chk("s5_best_mode_held", best_mode, 0);

    // Tie at 50: the lower index keeps the win.
    sums = '{32'd50, 32'd50, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    run_search(4'd2, 16'd0, 18, -1);
    chk("s2_done_count", g_dones, 1);
    chk("s2_best_mode", best_mode, 0);
    chk("s2_best_score", best_score, 50);

    // Saturated score equals the initial best, so nothing changes.
    rates = '{default: 16'hFFFF};
    sums  = '{default: 32'hFFFF_FFFF};
    run_search(4'd1, 16'hFFFF, 18, -1);
    chk("s3_best_score", best_score, 32'hFFFF_FFFF);
    chk("s3_best_mode", best_mode, 0);
    chk("s3_err", err, 0);

    // Saturation path on a winning mode: 5 + 0xFFFF*0xFFFF fits, 0xFFFF_FFF0 + ... saturates.
    rates = '{16'd2, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    sums  = '{32'hFFFF_FFF0, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    run_search(4'd2, 16'hFFFF, 18, -1);
    chk("sat_best_mode", best_mode, 1);
    chk("sat_best_score", best_score, 32'hFFFE_0006);

    // Engine never answers: timeout after 64 cycles, err set.
    run_search(4'd1, 16'd1, 0, -1);
    chk("s4_err", err, 1);
    chk("s4_done_count", g_dones, 1);
    chk("s4_done_after_eng_start", g_done_cyc - g_es_cyc, 64);
    chk("s4_best_score", best_score, 32'hFFFF_FFFF);

    // Zero modes skips straight to FIN.
    run_search(4'd0, 16'd3, 18, -1);
    chk("s6_zero_done_cycle", g_done_cyc, 1);
    chk("s6_zero_starts", g_starts, 0);
    chk("s6_zero_best_score", best_score, 32'hFFFF_FFFF);
    chk("s6_zero_best_mode", best_mode, 0);

    // 12 requested modes clamp to 8.
    rates = '{default: 16'd0};
    sums  = '{32'd80, 32'd70, 32'd60, 32'd50, 32'd40, 32'd30, 32'd20, 32'd25};
    run_search(4'd12, 16'd0, 18, -1);
    chk("s6_clamp_starts", g_starts, 8);
    chk("s6_clamp_mask", g_mask, 32'hFF);
    chk("s6_clamp_done_count", g_dones, 1);
    chk("s6_clamp_best_mode", best_mode, 6);
    chk("s6_clamp_best_score", best_score, 20);

    // abort beats start in the same IDLE cycle.
    num_modes = 4'd2; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    step();
    chk("abort_start_done", done, 0);

    // Reset mid-search: back to IDLE with cleared results and no done.
    num_modes = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_best_score", best_score, 0);
    step(); step();
    chk("mid_rst_no_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
